// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - captures a parallel word and streams it out as COUNT chunks
// Define P2S_LSB_FIRST_EN to emit the least-significant chunk first (default: MSB first).
module parallel_to_serial #(
  parameter int DATA_SIZE = 8,
  parameter int WIDTH     = 32,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     D,
  output logic                 ready,
  input  logic                 en,
  output logic [DATA_SIZE-1:0] Q,
  output logic                 valid,
  output logic                 busy,
  output logic                 done
);

  localparam int SW = COUNT * DATA_SIZE;
  localparam int CW = $clog2(COUNT) + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               r_state;
  logic [SW-1:0]        r_sreg;
  logic [CW-1:0]        r_cnt;
  logic                 r_done;
  logic [SW-1:0]        w_shifted;
  logic [DATA_SIZE-1:0] w_chunk;

`ifdef P2S_LSB_FIRST_EN
  assign w_chunk   = r_sreg[DATA_SIZE-1:0];
  assign w_shifted = r_sreg >> DATA_SIZE;
`else
  assign w_chunk   = r_sreg[SW-1 -: DATA_SIZE];
  assign w_shifted = r_sreg << DATA_SIZE;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (load) begin
            r_sreg  <= D[SW-1:0];
            r_cnt   <= CW'(COUNT);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          // en=0 stalls: every register holds so Q stays stable
          if (en) begin
            r_sreg <= w_shifted;
            r_cnt  <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign valid = (r_state == SHIFT);
  assign busy  = (r_state == SHIFT);
  assign ready = (r_state == IDLE);
  assign done  = r_done;
  assign Q     = valid ? w_chunk : '0;

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb/tb_parallel_to_serial.sv - vector table, corner sequences and randomized run against a queue model
module tb_parallel_to_serial;
  localparam int DS = 8;
  localparam int W  = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst, load, en;
  logic [W-1:0]  D;
  logic          ready, valid, busy, done;
  logic [DS-1:0] Q;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DS-1:0] m_q[$];
  logic          m_done = 1'b0;

  typedef struct {
    logic          rst;
    logic          load;
    logic [W-1:0]  d;
    logic          en;
    logic          v;
    logic [DS-1:0] q;
    logic          dn;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  parallel_to_serial #(.DATA_SIZE(DS), .WIDTH(W), .COUNT(N)) dut (
    .clk(clk), .rst(rst), .load(load), .D(D), .ready(ready), .en(en),
    .Q(Q), .valid(valid), .busy(busy), .done(done)
  );

  function automatic logic [DS-1:0] chunk(input logic [W-1:0] d, input int k);
`ifdef P2S_LSB_FIRST_EN
    return d[k*DS +: DS];
`else
    return d[(N-1-k)*DS +: DS];
`endif
  endfunction

  function automatic logic [DS+3:0] expv(input logic v, input logic dn, input logic [DS-1:0] q);
    return {v, v, ~v, dn, q};
  endfunction

  function automatic logic [DS+3:0] obs();
    return {valid, busy, ready, done, Q};
  endfunction

  // Model: a word is a queue of pending chunks; outputs follow from its occupancy
  task automatic tick(input logic r, input logic l, input logic [W-1:0] d, input logic e);
    rst = r; load = l; D = d; en = e;
    if (r) begin
      m_q.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_q.size() != 0) begin
        if (e) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1'b1;
        end
      end else if (l) begin
        for (int k = 0; k < N; k++) m_q.push_back(chunk(d, k));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DS+3:0] act, input logic [DS+3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {v,b,r,d,q}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic l, input logic [W-1:0] d, input logic e,
                     input logic v, input logic [DS-1:0] q, input logic dn);
    vec_t x;
    x.rst = r; x.load = l; x.d = d; x.en = e; x.v = v; x.q = q; x.dn = dn;
    vecs.push_back(x);
  endtask

  initial begin
    logic [W-1:0] wa, wb;
    logic         r, l, e;
    rst = 1'b1; load = 1'b0; en = 1'b0; D = '0;
    wa = 32'hA1B2C3D4;

    add(1, 0, 0, 0, 0, 8'h00, 0);
    add(1, 0, 0, 0, 0, 8'h00, 0);
`ifdef P2S_LSB_FIRST_EN
    add(0, 1, wa, 1, 1, 8'hD4, 0);
    add(0, 0, 0,  1, 1, 8'hC3, 0);
    add(0, 0, 0,  1, 1, 8'hB2, 0);
    add(0, 0, 0,  1, 1, 8'hA1, 0);
    add(0, 0, 0,  1, 0, 8'h00, 1);
    add(0, 0, 0,  1, 0, 8'h00, 0);
`else
    add(0, 1, wa, 1, 1, 8'hA1, 0);
    add(0, 0, 0,  1, 1, 8'hB2, 0);
    add(0, 0, 0,  1, 1, 8'hC3, 0);
    add(0, 0, 0,  1, 1, 8'hD4, 0);
    add(0, 0, 0,  1, 0, 8'h00, 1);
    add(0, 0, 0,  1, 0, 8'h00, 0);
    // stall pattern 1,0,0,1,1,0,1
    add(0, 1, wa, 0, 1, 8'hA1, 0);
    add(0, 0, 0,  1, 1, 8'hB2, 0);
    add(0, 0, 0,  0, 1, 8'hB2, 0);
    add(0, 0, 0,  0, 1, 8'hB2, 0);
    add(0, 0, 0,  1, 1, 8'hC3, 0);
    add(0, 0, 0,  1, 1, 8'hD4, 0);
    add(0, 0, 0,  0, 1, 8'hD4, 0);
    add(0, 0, 0,  1, 0, 8'h00, 1);
    add(0, 0, 0,  0, 0, 8'h00, 0);
    // load while busy is dropped
    add(0, 1, wa,           0, 1, 8'hA1, 0);
    add(0, 0, 0,            1, 1, 8'hB2, 0);
    add(0, 1, 32'h11223344, 0, 1, 8'hB2, 0);
    add(0, 0, 0,            1, 1, 8'hC3, 0);
    add(0, 0, 0,            1, 1, 8'hD4, 0);
    add(0, 0, 0,            1, 0, 8'h00, 1);
    add(0, 0, 0,            1, 0, 8'h00, 0);
    add(0, 0, 0,            1, 0, 8'h00, 0);
`endif

    foreach (vecs[i]) begin
      tick(vecs[i].rst, vecs[i].load, vecs[i].d, vecs[i].en);
      check($sformatf("vec%0d", i), obs(), expv(vecs[i].v, vecs[i].dn, vecs[i].q));
    end

    // back-to-back: second load lands in the done cycle of the first word
    wb = 32'h01020304;
    tick(0, 1, wa, 1);
    check("b2b_w0_c0", obs(), expv(1, 0, chunk(wa, 0)));
    for (int k = 1; k < N; k++) begin
      tick(0, 0, 0, 1);
      check($sformatf("b2b_w0_c%0d", k), obs(), expv(1, 0, chunk(wa, k)));
    end
    tick(0, 0, 0, 1);
    check("b2b_w0_done", obs(), expv(0, 1, 8'h00));
    tick(0, 1, wb, 1);
    check("b2b_w1_c0", obs(), expv(1, 0, chunk(wb, 0)));
    for (int k = 1; k < N; k++) begin
      tick(0, 0, 0, 1);
      check($sformatf("b2b_w1_c%0d", k), obs(), expv(1, 0, chunk(wb, k)));
    end
    tick(0, 0, 0, 1);
    check("b2b_w1_done", obs(), expv(0, 1, 8'h00));

    // reset during the third chunk abandons the word with no done
    tick(0, 1, wa, 1);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    check("rstmid_c2", obs(), expv(1, 0, chunk(wa, 2)));
    tick(1, 0, 0, 1);
    check("rstmid_rst", obs(), expv(0, 0, 8'h00));
    tick(0, 0, 0, 1);
    check("rstmid_nodone", obs(), expv(0, 0, 8'h00));
    wb = 32'h0F0E0D0C;
    tick(0, 1, wb, 1);
    check("rstmid_new_c0", obs(), expv(1, 0, chunk(wb, 0)));
    for (int k = 1; k < N; k++) begin
      tick(0, 0, 0, 1);
      check($sformatf("rstmid_new_c%0d", k), obs(), expv(1, 0, chunk(wb, k)));
    end
    tick(0, 0, 0, 1);
    check("rstmid_new_done", obs(), expv(0, 1, 8'h00));

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 2) == 0);
      e = ($urandom_range(0, 3) != 0);
      tick(r, l, $urandom, e);
      check($sformatf("rand%0d", i), obs(),
            expv(m_q.size() != 0, m_done, (m_q.size() != 0) ? m_q[0] : 8'h00));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
